cs_bus_sequencer: RTL

- Two-requester bus access controller placed in front of the 4-region chip-select address decoder.
- Arbitrates round-robin between two requesters and latches the winner's address.
- Drives the decoder's addr and active-low CS inputs with a setup / strobe / hold sequence.
- Strobe length is set per region, where the region is selected by addr[7:6].
- Returns a one-cycle acknowledge to the winning requester.

---
 rtl/cs_bus_sequencer_if.sv | 26 ++
 rtl/cs_bus_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/cs_bus_sequencer_if.sv
// rtl/cs_bus_sequencer_if.sv - requester handshake and decoder bus bundle
interface cs_bus_sequencer_if #(
  parameter int AW = 8
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic          ack0;
  logic          ack1;
  logic [1:0]    gnt;
  logic          busy;
  logic [AW-1:0] bus_addr;
  logic          bus_cs_n;

  // The sequencer serves requests, so it takes the slave view of the handshake.
  modport slave (
    input  req0, addr0, req1, addr1,
    output ack0, ack1, gnt, busy, bus_addr, bus_cs_n
  );

  modport master (
    output req0, addr0, req1, addr1,
    input  ack0, ack1, gnt, busy, bus_addr, bus_cs_n
  );
endinterface

// File: rtl/cs_bus_sequencer.sv
// rtl/cs_bus_sequencer.sv - two-requester round-robin chip-select access sequencer
module cs_bus_sequencer #(
  parameter int          AW    = 8,
  parameter int unsigned WAIT0 = 0,
  parameter int unsigned WAIT1 = 1,
  parameter int unsigned WAIT2 = 2,
  parameter int unsigned WAIT3 = 3
) (
  input logic             clk,
  input logic             rst_n,
  cs_bus_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  state_t        next_state;
  logic [3:0]    wcnt;
  logic          last_gnt;
  logic          grant_valid;
  logic          grant_id;
  logic [AW-1:0] grant_addr;

  function automatic logic [3:0] region_wait(input logic [1:0] region);
    case (region)
      2'b00:   region_wait = 4'(WAIT0);
      2'b01:   region_wait = 4'(WAIT1);
      2'b10:   region_wait = 4'(WAIT2);
      default: region_wait = 4'(WAIT3);
    endcase
  endfunction

  // On contention the requester that did not win last time goes next.
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    grant_id    = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_id = ~last_gnt;
    end else if (bus.req1) begin
      grant_id = 1'b1;
    end
    grant_addr = grant_id ? bus.addr1 : bus.addr0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = SETUP;
      SETUP:   next_state = STROBE;
      STROBE:  if (wcnt == 4'd0) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so every one of them comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_addr <= '0;
      bus.bus_cs_n <= 1'b1;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.gnt      <= 2'b00;
      bus.busy     <= 1'b0;
      wcnt         <= 4'd0;
      last_gnt     <= 1'b1;
    end else begin
      bus.busy     <= (next_state != IDLE);
      bus.bus_cs_n <= (next_state != STROBE);
      bus.ack0     <= (next_state == HOLD) && bus.gnt[0];
      bus.ack1     <= (next_state == HOLD) && bus.gnt[1];
      if (state == IDLE && grant_valid) begin
        bus.bus_addr <= grant_addr;
        bus.gnt      <= grant_id ? 2'b10 : 2'b01;
        last_gnt     <= grant_id;
        wcnt         <= region_wait(grant_addr[AW-1:AW-2]);
      end else if (state == STROBE && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (state == HOLD) begin
        bus.gnt <= 2'b00;
      end
    end
  end

endmodule
